// File: rtl/drsstc_cfg_ctrl_pkg.sv
// drsstc_cfg_ctrl_pkg: parser states, frame sync byte, register addresses and error codes
package drsstc_cfg_ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LO,
      S_HI,
      S_CHK,
      S_CHECK,
      S_COMMIT
   } state_t;
   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam logic [1:0] ADDR_ONTIME = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_EN     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd0;
   localparam logic [1:0] ERR_ADDR    = 2'd1;
   localparam logic [1:0] ERR_RANGE   = 2'd2;
   localparam logic [1:0] ERR_CHK     = 2'd3;
endpackage

// File: rtl/drsstc_cfg_ctrl_cfg_shadow.sv
// drsstc_cfg_ctrl_cfg_shadow: pending value register that writes the live interrupter registers only between bursts
module drsstc_cfg_ctrl_cfg_shadow
   import drsstc_cfg_ctrl_pkg::*;
#(
   parameter int STOR_W     = 16,
   parameter int PERIOD_DEF = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [1:0]        load_addr,
   input  logic [STOR_W-1:0] load_val,
   input  logic              burst_idle,
   output logic [STOR_W-1:0] ontime,
   output logic [STOR_W-1:0] period,
   output logic              out_en,
   output logic              cfg_update,
   output logic              applied
);
   logic              pend_vld;
   logic [1:0]        pend_addr;
   logic [STOR_W-1:0] pend_val;

   // enable writes never wait; timing writes wait until no burst can be in flight
   assign applied = pend_vld && (burst_idle || !out_en || pend_addr == ADDR_EN);

   // stage the checked value, then apply it and pulse cfg_update on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld   <= 1'b0;
         pend_addr  <= ADDR_ONTIME;
         pend_val   <= '0;
         ontime     <= '0;
         period     <= STOR_W'(PERIOD_DEF);
         out_en     <= 1'b0;
         cfg_update <= 1'b0;
      end else begin
         cfg_update <= applied;
         if (load) begin
            pend_vld  <= 1'b1;
            pend_addr <= load_addr;
            pend_val  <= load_val;
         end else if (applied) begin
            pend_vld <= 1'b0;
         end
         if (applied && pend_addr == ADDR_ONTIME) ontime <= pend_val;
         if (applied && pend_addr == ADDR_PERIOD) period <= pend_val;
         if (applied && pend_addr == ADDR_EN) out_en <= pend_val[0];
      end
   end
endmodule

// File: rtl/drsstc_cfg_ctrl.sv
// drsstc_cfg_ctrl: UART frame parser that range-checks settings and hands them to the burst-safe shadow
// Build option: define CFG_CHECKSUM_EN for 5-byte frames ending in an ADDR^LO^HI check byte
module drsstc_cfg_ctrl
   import drsstc_cfg_ctrl_pkg::*;
#(
   parameter int STOR_W      = 16,
   parameter int ONTIME_MAX  = 400,
   parameter int PERIOD_MIN  = 1000,
   parameter int PERIOD_DEF  = 50000,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              burst_idle,
   output logic [STOR_W-1:0] ontime,
   output logic [STOR_W-1:0] period,
   output logic              out_en,
   output logic              cfg_update,
   output logic              err,
   output logic [1:0]        err_code
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
`ifdef CFG_CHECKSUM_EN
   localparam state_t HI_NEXT = S_CHK;
`else
   localparam state_t HI_NEXT = S_CHECK;
`endif

   state_t            state, state_nx;
   logic [7:0]        addr, data_lo, data_hi;
   logic [CNT_W-1:0]  cnt;
   logic [STOR_W-1:0] value;
   logic [1:0]        reject_code;
   logic              take, in_frame, expire;
   logic              bad_addr, bad_range, bad_chk, reject, load, applied;

   assign rx_ready    = !(state inside {S_CHECK, S_COMMIT});
   assign take        = rx_valid && rx_ready;
   assign in_frame    = state inside {S_ADDR, S_LO, S_HI, S_CHK};
   assign expire      = in_frame && !take && cnt == '0;
   assign value       = STOR_W'({data_hi, data_lo});
   assign bad_addr    = addr > 8'(ADDR_EN);
   assign bad_range   = (addr == 8'(ADDR_ONTIME) && value > STOR_W'(ONTIME_MAX)) ||
                        (addr == 8'(ADDR_PERIOD) && value < STOR_W'(PERIOD_MIN));
`ifdef CFG_CHECKSUM_EN
   logic [7:0] data_chk;
   assign bad_chk     = data_chk != (addr ^ data_lo ^ data_hi);
`else
   assign bad_chk     = 1'b0;
`endif
   assign reject_code = bad_addr ? ERR_ADDR : bad_range ? ERR_RANGE : ERR_CHK;
   assign reject      = state == S_CHECK && (bad_addr || bad_range || bad_chk);
   assign load        = state == S_CHECK && !reject;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // frame walk; a stalled frame is abandoned regardless of which byte it was waiting for
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   state_nx = (take && rx_data == SYNC_BYTE) ? S_ADDR : S_IDLE;
         S_ADDR:   state_nx = take ? S_LO : S_ADDR;
         S_LO:     state_nx = take ? S_HI : S_LO;
         S_HI:     state_nx = take ? HI_NEXT : S_HI;
         S_CHK:    state_nx = take ? S_CHECK : S_CHK;
         S_CHECK:  state_nx = reject ? S_IDLE : S_COMMIT;
         S_COMMIT: state_nx = applied ? S_IDLE : S_COMMIT;
         default:  state_nx = S_IDLE;
      endcase
      if (expire) state_nx = S_IDLE;
   end

   // byte capture, inter-byte timeout and error reporting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         data_lo  <= '0;
         data_hi  <= '0;
`ifdef CFG_CHECKSUM_EN
         data_chk <= '0;
`endif
         cnt      <= CNT_LOAD;
         err      <= 1'b0;
         err_code <= ERR_TIMEOUT;
      end else begin
         err <= reject || expire;
         if (reject) err_code <= reject_code;
         else if (expire) err_code <= ERR_TIMEOUT;
         if (take) cnt <= CNT_LOAD;
         else if (in_frame && cnt != '0) cnt <= cnt - CNT_W'(1);
         if (take && state == S_ADDR) addr <= rx_data;
         if (take && state == S_LO) data_lo <= rx_data;
         if (take && state == S_HI) data_hi <= rx_data;
`ifdef CFG_CHECKSUM_EN
         if (take && state == S_CHK) data_chk <= rx_data;
`endif
      end
   end

   drsstc_cfg_ctrl_cfg_shadow #(
      .STOR_W    (STOR_W),
      .PERIOD_DEF(PERIOD_DEF)
   ) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_addr (addr[1:0]),
      .load_val  (value),
      .burst_idle(burst_idle),
      .ontime    (ontime),
      .period    (period),
      .out_en    (out_en),
      .cfg_update(cfg_update),
      .applied   (applied)
   );
endmodule

// File: tb/tb_drsstc_cfg_ctrl.sv
// tb_drsstc_cfg_ctrl: directed and random frames checked every cycle against a frame-level model
module tb_drsstc_cfg_ctrl;
   localparam int STOR_W     = 16;
   localparam int ONTIME_MAX = 400;
   localparam int PERIOD_MIN = 1000;
   localparam int PERIOD_DEF = 50000;
   localparam int T          = 64;
`ifdef CFG_CHECKSUM_EN
   localparam int FL = 5;
`else
   localparam int FL = 4;
`endif

   logic        clk = 0, rst_n = 0, rx_valid = 0, burst_idle = 0;
   logic [7:0]  rx_data = 0;
   logic        rx_ready, out_en, cfg_update, err;
   logic [15:0] ontime, period;
   logic [1:0]  err_code;
   int          checks = 0, errors = 0;
   int          bi_mode = 1;

   always #5 clk = ~clk;

   drsstc_cfg_ctrl #(
      .STOR_W(STOR_W), .ONTIME_MAX(ONTIME_MAX), .PERIOD_MIN(PERIOD_MIN),
      .PERIOD_DEF(PERIOD_DEF), .TIMEOUT_CYC(T)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .burst_idle(burst_idle), .ontime(ontime), .period(period), .out_en(out_en),
      .cfg_update(cfg_update), .err(err), .err_code(err_code)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // burst_idle source: 0 held low, 1 held high, 2 random
   always @(posedge clk) begin
      #1;
      burst_idle = (bi_mode == 2) ? ($urandom_range(0, 3) == 0) : (bi_mode == 1);
   end

   // frame-level model: collected bytes, idle gap since last byte, validation and commit phases
   logic [7:0]  q[$];
   int          gap, pa, ma;
   bit          checking, committing, mtake;
   logic [15:0] pv, mv, m_on, m_per;
   bit          m_en, m_upd, m_err, mck;
   logic [1:0]  m_code;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         gap = 0; checking = 0; committing = 0;
         m_on = 0; m_per = PERIOD_DEF; m_en = 0; m_upd = 0; m_err = 0; m_code = 0;
      end else begin
         mtake = rx_valid && !(checking || committing);
         m_upd = 0;
         m_err = 0;
         if (committing) begin
            if (burst_idle || !m_en || pa == 2) begin
               if (pa == 0) m_on = pv;
               if (pa == 1) m_per = pv;
               if (pa == 2) m_en = pv[0];
               m_upd = 1;
               committing = 0;
            end
         end else if (checking) begin
            ma = int'(q[1]);
            mv = {q[3], q[2]};
            mck = 0;
`ifdef CFG_CHECKSUM_EN
            mck = q[4] != (q[1] ^ q[2] ^ q[3]);
`endif
            checking = 0;
            q.delete();
            if (ma > 2) begin m_err = 1; m_code = 1; end
            else if ((ma == 0 && mv > ONTIME_MAX) || (ma == 1 && mv < PERIOD_MIN)) begin m_err = 1; m_code = 2; end
            else if (mck) begin m_err = 1; m_code = 3; end
            else begin committing = 1; pa = ma; pv = mv; end
         end else if (mtake) begin
            gap = 0;
            if (q.size() > 0 || rx_data == 8'hA5) q.push_back(rx_data);
            if (q.size() == FL) checking = 1;
         end else if (q.size() > 0) begin
            gap++;
            if (gap >= T) begin q.delete(); m_err = 1; m_code = 0; end
         end
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (rst_n) begin
         check("ontime", ontime, m_on);
         check("period", period, m_per);
         check("out_en", out_en, m_en);
         check("cfg_update", cfg_update, m_upd);
         check("err", err, m_err);
         check("err_code", err_code, m_code);
         check("rx_ready", rx_ready, !(checking || committing));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic send(input logic [7:0] b);
      int   n;
      logic r;
      n = 0;
      rx_data = b;
      rx_valid = 1;
      do begin r = rx_ready; cyc(); n++; end while (!r && n < 2000);
      if (!r) check("byte_accept", r, 1);
      rx_valid = 0;
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi);
      send(8'hA5); send(a); send(lo); send(hi);
`ifdef CFG_CHECKSUM_EN
      send(a ^ lo ^ hi);
`endif
   endtask

   function automatic int rgap();
      int r;
      r = $urandom_range(0, 31);
      return r == 0 ? T : r == 1 ? T - 1 : r == 2 ? T + 5 : $urandom_range(0, 2);
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  fb[5];
      logic [15:0] val;
      int          sel;
      cyc(3);
      rst_n = 1;
      check("rst_ontime", ontime, 0);
      check("rst_period", period, 50000);
      check("rst_out_en", out_en, 0);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_err", err, 0);
      check("rst_cfg_update", cfg_update, 0);
      check("rst_err_code", err_code, 0);
      frame(8'h00, 8'h2C, 8'h01);
      cyc();
      check("lat_upd_early", cfg_update, 0);
      check("lat_ontime_early", ontime, 0);
      cyc();
      check("lat_upd", cfg_update, 1);
      check("ontime_300", ontime, 300);
      cyc();
      check("upd_one_cycle", cfg_update, 0);
      frame(8'h00, 8'hF4, 8'h01);
      cyc();
      check("range_err", err, 1);
      check("range_code", err_code, 2);
      cyc();
      check("err_one_cycle", err, 0);
      check("range_ontime_kept", ontime, 300);
      frame(8'h00, 8'h90, 8'h01);
      cyc(2);
      check("ontime_400", ontime, 400);
      frame(8'h00, 8'h91, 8'h01);
      cyc();
      check("ontime_401_code", err_code, 2);
      frame(8'h00, 8'hA5, 8'h00);
      cyc(2);
      check("sync_as_data", ontime, 165);
      frame(8'h01, 8'hE7, 8'h03);
      cyc();
      check("period_999_code", err_code, 2);
      frame(8'h01, 8'hE8, 8'h03);
      cyc(2);
      check("period_1000", period, 1000);
      frame(8'h02, 8'h01, 8'h00);
      cyc(2);
      check("out_en_on", out_en, 1);
      bi_mode = 0;
      frame(8'h01, 8'h10, 8'h27);
      cyc(50);
      check("wait_rx_ready", rx_ready, 0);
      check("wait_period", period, 1000);
      bi_mode = 1;
      cyc();
      check("wait_period_edge", period, 1000);
      cyc();
      check("period_10000", period, 10000);
      check("period_upd", cfg_update, 1);
      bi_mode = 0;
      frame(8'h02, 8'h00, 8'h00);
      cyc(2);
      check("out_en_immediate", out_en, 0);
      bi_mode = 1;
      frame(8'h05, 8'h00, 8'h00);
      cyc();
      check("addr_err", err, 1);
      check("addr_code", err_code, 1);
      send(8'hA5); send(8'h00);
      cyc(T - 1);
      check("no_timeout_yet", err, 0);
      cyc();
      check("timeout_err", err, 1);
      check("timeout_code", err_code, 0);
      check("timeout_idle", rx_ready, 1);
      frame(8'h00, 8'h64, 8'h00);
      cyc(2);
      check("after_timeout", ontime, 100);
      send(8'hA5);
      cyc(T - 1);
      send(8'h00); send(8'h2C); send(8'h01);
`ifdef CFG_CHECKSUM_EN
      send(8'h2D);
`endif
      cyc(2);
      check("byte_wins", ontime, 300);
`ifdef CFG_CHECKSUM_EN
      send(8'hA5); send(8'h00); send(8'h2C); send(8'h01); send(8'h00);
      cyc();
      check("chk_code", err_code, 3);
`endif
      frame(8'h02, 8'h01, 8'h00);
      cyc(2);
      send(8'hA5); send(8'h00); send(8'h2C);
      rst_n = 0;
      #1;
      check("mid_rst_ontime", ontime, 0);
      check("mid_rst_period", period, 50000);
      check("mid_rst_out_en", out_en, 0);
      check("mid_rst_rx_ready", rx_ready, 1);
      cyc();
      rst_n = 1;
      bi_mode = 2;
      repeat (200) begin
         if ($urandom_range(0, 7) == 0) send(8'($urandom_range(0, 255)));
         sel = $urandom_range(0, 9);
         fb[0] = 8'hA5;
         fb[1] = sel < 3 ? 8'd0 : sel < 6 ? 8'd1 : sel < 8 ? 8'd2 : sel == 8 ? 8'($urandom_range(3, 255)) : 8'hA5;
         sel = $urandom_range(0, 5);
         val = sel == 0 ? 16'(ONTIME_MAX - 1 + $urandom_range(0, 2)) :
               sel == 1 ? 16'(PERIOD_MIN - 1 + $urandom_range(0, 2)) :
               sel == 2 ? 16'($urandom_range(0, 65535)) :
               sel == 3 ? 16'($urandom_range(0, 500)) :
               sel == 4 ? 16'($urandom_range(1000, 60000)) : 16'hA5A5;
         fb[2] = val[7:0];
         fb[3] = val[15:8];
         fb[4] = fb[1] ^ fb[2] ^ fb[3] ^ (($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
         for (int i = 0; i < FL; i++) begin
            if (i > 0) cyc(rgap());
            send(fb[i]);
         end
         cyc($urandom_range(0, 3));
      end
      bi_mode = 1;
      cyc(10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
